rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 169 ++++++++++++++++
 tb/tb_rob_commit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// ROB commit stage: retires the head entry, issues stores to data memory and
// waits for their ack, then writes back and releases the ROB tag.
// Optional COMMIT_PERF_CNT_EN enables the retire / store-stall counters.
module rob_commit #(
  parameter int unsigned ADDR = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            head_valid,
  input  logic            rob_empty,
  input  logic [ADDR-1:0] head_idx,
  input  logic [113:0]    rob_entry,
  input  logic            dmem_ack,
  output logic            head_pop,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [31:0]     rf_wd,
  output logic            dmem_req,
  output logic [31:0]     dmem_addr,
  output logic [31:0]     dmem_wd,
  output logic            tag_rel_valid,
  output logic [ADDR-1:0] tag_rel_idx,
  output logic            busy,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     stall_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {IDLE, STORE_WAIT} state_t;

  state_t r_state, w_state_nxt;

  logic              w_commit, w_store_start;
  logic              w_ret_rw;
  logic [REG_W-1:0]  w_ret_dest;
  logic [DATA_W-1:0] w_ret_result;
  logic [ADDR-1:0]   w_ret_idx;

  logic              r_cap_rw;
  logic [REG_W-1:0]  r_cap_dest;
  logic [DATA_W-1:0] r_cap_result;
  logic [ADDR-1:0]   r_cap_idx;

  logic              r_dmem_req, r_rf_we, r_tag_rel_valid;
  logic [DATA_W-1:0] r_dmem_addr, r_dmem_wd, r_rf_wd;
  logic [REG_W-1:0]  r_rf_wa;
  logic [ADDR-1:0]   r_tag_rel_idx;

  // Branch flag, upper control bits and pc_plus4 are not needed at commit.
  logic w_unused_entry;
  assign w_unused_entry = ^{rob_entry[43:34], rob_entry[31:0]};

  assign w_commit = head_valid & ~rob_empty & rob_entry[113];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, retire pulse and retire-field selection (live entry or captured store).
  always_comb begin
    w_state_nxt   = r_state;
    head_pop      = 1'b0;
    w_store_start = 1'b0;
    w_ret_rw      = rob_entry[32];
    w_ret_dest    = rob_entry[112:108];
    w_ret_result  = rob_entry[107:76];
    w_ret_idx     = head_idx;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          if (rob_entry[33]) begin
            w_store_start = 1'b1;
            w_state_nxt   = STORE_WAIT;
          end else begin
            head_pop = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        w_ret_rw     = r_cap_rw;
        w_ret_dest   = r_cap_dest;
        w_ret_result = r_cap_result;
        w_ret_idx    = r_cap_idx;
        if (dmem_ack) begin
          head_pop    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rstn) head_pop = 1'b0;
  end

  // Store request and captured entry, held stable through STORE_WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dmem_req   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wd    <= '0;
      r_cap_rw     <= 1'b0;
      r_cap_dest   <= '0;
      r_cap_result <= '0;
      r_cap_idx    <= '0;
    end else if (w_store_start) begin
      r_dmem_req   <= 1'b1;
      r_dmem_addr  <= rob_entry[107:76];
      r_dmem_wd    <= rob_entry[75:44];
      r_cap_rw     <= rob_entry[32];
      r_cap_dest   <= rob_entry[112:108];
      r_cap_result <= rob_entry[107:76];
      r_cap_idx    <= head_idx;
    end else if ((r_state == STORE_WAIT) && dmem_ack) begin
      r_dmem_req <= 1'b0;
    end
  end

  // Writeback and tag release one cycle after each retire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rf_we         <= 1'b0;
      r_rf_wa         <= '0;
      r_rf_wd         <= '0;
      r_tag_rel_valid <= 1'b0;
      r_tag_rel_idx   <= '0;
    end else begin
      r_rf_we         <= head_pop & w_ret_rw & (w_ret_dest != REG_W'(0));
      r_tag_rel_valid <= head_pop;
      if (head_pop) begin
        r_rf_wa       <= w_ret_dest;
        r_rf_wd       <= w_ret_result;
        r_tag_rel_idx <= w_ret_idx;
      end
    end
  end

  assign dmem_req      = r_dmem_req;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wd       = r_dmem_wd;
  assign rf_we         = r_rf_we;
  assign rf_wa         = r_rf_wa;
  assign rf_wd         = r_rf_wd;
  assign tag_rel_valid = r_tag_rel_valid;
  assign tag_rel_idx   = r_tag_rel_idx;
  assign busy          = (r_state == STORE_WAIT);

`ifdef COMMIT_PERF_CNT_EN
  logic [DATA_W-1:0] r_retire_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (head_pop)               r_retire_cnt <= r_retire_cnt + DATA_W'(1);
      if (r_state == STORE_WAIT)  r_stall_cnt  <= r_stall_cnt + DATA_W'(1);
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus queues expected writeback/tag
// events, a negedge monitor compares head_pop, rf, tag and store outputs.
module tb_rob_commit;

  localparam int unsigned ADDR = 7;

  logic            clk = 1'b0;
  logic            rstn;
  logic            head_valid, rob_empty, dmem_ack;
  logic [ADDR-1:0] head_idx;
  logic [113:0]    rob_entry;
  logic            head_pop, rf_we, dmem_req, tag_rel_valid, busy;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd, dmem_addr, dmem_wd, retire_cnt, stall_cnt;
  logic [ADDR-1:0] tag_rel_idx;

  rob_commit #(.ADDR(ADDR)) dut (
    .clk(clk), .rstn(rstn), .head_valid(head_valid), .rob_empty(rob_empty),
    .head_idx(head_idx), .rob_entry(rob_entry), .dmem_ack(dmem_ack),
    .head_pop(head_pop), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .tag_rel_valid(tag_rel_valid), .tag_rel_idx(tag_rel_idx), .busy(busy),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [4:0] wa; logic [31:0] wd; } rf_exp_t;
  typedef struct { int due; logic [ADDR-1:0] idx; } tag_exp_t;

  rf_exp_t  q_rf[$];
  tag_exp_t q_tag[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          exp_retire = 0;
  int          exp_stall = 0;
  logic        exp_pop = 1'b0;
  logic        exp_st = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wd = '0;

  always @(posedge clk) cyc++;

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    errors++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // Monitor: compare every output event against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      logic rf_due, tag_due;
      checks++;
      if (head_pop !== exp_pop) fail("head_pop", 64'(head_pop), 64'(exp_pop));

      rf_due = (q_rf.size() > 0) && (q_rf[0].due == cyc);
      if (rf_we || rf_due) begin
        checks++;
        if (!rf_due) fail("rf_we_unexpected", {rf_wa, rf_wd}, 64'(0));
        else if (rf_we !== 1'b1) fail("rf_we_missing", 64'(rf_we), 64'(1));
        else if ({rf_wa, rf_wd} !== {q_rf[0].wa, q_rf[0].wd})
          fail("rf_wa_wd", {rf_wa, rf_wd}, {q_rf[0].wa, q_rf[0].wd});
        if (rf_due) void'(q_rf.pop_front());
      end

      tag_due = (q_tag.size() > 0) && (q_tag[0].due == cyc);
      if (tag_rel_valid || tag_due) begin
        checks++;
        if (!tag_due) fail("tag_unexpected", 64'(tag_rel_idx), 64'(0));
        else if (tag_rel_valid !== 1'b1) fail("tag_missing", 64'(tag_rel_valid), 64'(1));
        else if (tag_rel_idx !== q_tag[0].idx) fail("tag_rel_idx", 64'(tag_rel_idx), 64'(q_tag[0].idx));
        if (tag_due) void'(q_tag.pop_front());
      end

      if (dmem_req) begin
        req_cyc++;
        checks++;
        if (!exp_st) fail("dmem_req_unexpected", 64'(dmem_req), 64'(0));
        else if ({dmem_addr, dmem_wd} !== {exp_addr, exp_wd})
          fail("dmem_addr_wd", {dmem_addr, dmem_wd}, {exp_addr, exp_wd});
      end
    end
  end

  function automatic logic [113:0] mk(input logic v, input logic [4:0] d, input logic [31:0] res,
                                      input logic [31:0] wd, input logic br, input logic mw,
                                      input logic rw);
    logic [113:0] e;
    e          = '0;
    e[113]     = v;
    e[112:108] = d;
    e[107:76]  = res;
    e[75:44]   = wd;
    e[34]      = br;
    e[33]      = mw;
    e[32]      = rw;
    e[31:0]    = 32'h0000_4000 + res;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_pop = 1'b0;
  endtask

  task automatic retire_exp(input logic [ADDR-1:0] idx, input logic rw, input logic [4:0] d,
                            input logic [31:0] res);
    tag_exp_t t;
    rf_exp_t  r;
    exp_pop = 1'b1;
    t.due = cyc + 1;
    t.idx = idx;
    q_tag.push_back(t);
    if (rw && d != 5'd0) begin
      r.due = cyc + 1;
      r.wa  = d;
      r.wd  = res;
      q_rf.push_back(r);
    end
    exp_retire++;
  endtask

  task automatic drive_alu(input logic [ADDR-1:0] idx, input logic [4:0] d, input logic [31:0] res,
                           input logic br, input logic rw);
    head_valid = 1'b1;
    rob_empty  = 1'b0;
    head_idx   = idx;
    rob_entry  = mk(1'b1, d, res, 32'h0, br, 1'b0, rw);
    retire_exp(idx, rw, d, res);
    tick();
  endtask

  task automatic idle_cyc();
    head_valid = 1'b0;
    rob_entry  = '0;
    tick();
  endtask

  task automatic chk_cnt(input string tag);
`ifdef COMMIT_PERF_CNT_EN
    chk({tag, "_retire_cnt"}, 64'(retire_cnt), 64'(exp_retire));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`else
    chk({tag, "_retire_cnt"}, 64'(retire_cnt), 64'(0));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
`endif
  endtask

  task automatic do_store(input logic [ADDR-1:0] idx, input logic [31:0] addr, input logic [31:0] wd,
                          input int wait_n);
    head_valid = 1'b1;
    rob_empty  = 1'b0;
    head_idx   = idx;
    rob_entry  = mk(1'b1, 5'd0, addr, wd, 1'b0, 1'b1, 1'b0);
    dmem_ack   = 1'b0;
    exp_st     = 1'b1;
    exp_addr   = addr;
    exp_wd     = wd;
    req_cyc    = 0;
    tick();
    chk("store_busy", 64'(busy), 64'(1));
    repeat (wait_n - 1) tick();
    dmem_ack = 1'b1;
    retire_exp(idx, 1'b0, 5'd0, addr);
    tick();
    dmem_ack   = 1'b0;
    head_valid = 1'b0;
    rob_entry  = '0;
    exp_st     = 1'b0;
    exp_stall += wait_n;
    chk("store_req_cycles", 64'(req_cyc), 64'(wait_n));
    chk("store_done_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rstn       = 1'b0;
    head_valid = 1'b0;
    rob_empty  = 1'b1;
    dmem_ack   = 1'b0;
    head_idx   = '0;
    rob_entry  = '0;
    #3;
    chk("rst_dmem", {31'(0), dmem_req, dmem_addr}, 64'(0));
    chk("rst_dmem_wd", 64'(dmem_wd), 64'(0));
    chk("rst_rf", {26'(0), rf_we, rf_wa, rf_wd}, 64'(0));
    chk("rst_tag", {56'(0), tag_rel_valid, tag_rel_idx}, 64'(0));
    chk("rst_busy_pop", {busy, head_pop}, 64'(0));
    chk_cnt("rst");
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // ALU write to r5, tag 3
    drive_alu(7'd3, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
    idle_cyc();
    // destReg 0 write suppressed, tag still released
    drive_alu(7'd4, 5'd0, 32'h0000_0BAD, 1'b0, 1'b1);
    // branch-only, RegWrite clear
    drive_alu(7'd5, 5'd7, 32'h0000_00B0, 1'b1, 1'b0);
    idle_cyc();

    // blocked commits: rob_empty, then invalid entry
    head_valid = 1'b1;
    rob_empty  = 1'b1;
    head_idx   = 7'd9;
    rob_entry  = mk(1'b1, 5'd3, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rob_empty = 1'b0;
    rob_entry = mk(1'b0, 5'd3, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    rob_entry[33] = 1'b1;
    tick();
    chk("blocked_busy", 64'(busy), 64'(0));
    idle_cyc();

    // store with ack on 4th wait cycle, then ALU back-to-back
    do_store(7'd6, 32'h0000_0100, 32'h0000_DEAD, 4);
    drive_alu(7'd7, 5'd12, 32'hCAFE_0001, 1'b0, 1'b1);
    idle_cyc();
    chk_cnt("after_store");

    // ack outside a store is ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_busy", 64'(busy), 64'(0));
    idle_cyc();

    // ten back-to-back ALU retires
    for (int i = 0; i < 10; i++)
      drive_alu(7'(10 + i), 5'(i + 1), 32'h0000_1000 + 32'(i), 1'b0, 1'(i % 2));
    idle_cyc();
    chk_cnt("b2b");

    // minimum-length store (ack in the first wait cycle)
    do_store(7'd40, 32'h0000_0200, 32'h1234_5678, 1);
    idle_cyc();
    chk_cnt("short_store");

    // reset in the middle of STORE_WAIT
    head_valid = 1'b1;
    rob_empty  = 1'b0;
    head_idx   = 7'd50;
    rob_entry  = mk(1'b1, 5'd0, 32'h300, 32'hBEEF, 1'b0, 1'b1, 1'b0);
    exp_st     = 1'b1;
    exp_addr   = 32'h300;
    exp_wd     = 32'hBEEF;
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2;
    exp_st = 1'b0;
    rstn   = 1'b0;
    #1;
    exp_retire = 0;
    exp_stall  = 0;
    chk("midrst_dmem_req", 64'(dmem_req), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_head_pop", 64'(head_pop), 64'(0));
    chk_cnt("midrst");
    rob_entry = mk(1'b1, 5'd2, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("inrst_head_pop", 64'(head_pop), 64'(0));
    chk("inrst_tag", 64'(tag_rel_valid), 64'(0));
    head_valid = 1'b0;
    rstn       = 1'b1;
    tick();
    drive_alu(7'd60, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_cyc();
    idle_cyc();
    chk_cnt("post_rst");

    chk("rf_queue_drained", 64'(q_rf.size()), 64'(0));
    chk("tag_queue_drained", 64'(q_tag.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
